mux2_sample_packer: RTL and testbench
=====================================

MUX2_SAMPLE_PACKER -- requirements
Module: mux2_sample_packer

Interface
REQ-001 Parameter WIDTH, default 8, output word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1; 1 = first accepted bit lands in bit 0, 0 = first accepted bit lands in bit WIDTH-1.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 y_in  input  1  serial data bit, the y output of the upstream 2:1 mux stage.
REQ-006 y_valid  input  1  y_in is valid this cycle.
REQ-007 y_ready  output  1  block accepts y_in this cycle.
REQ-008 flush  input  1  emit the partially filled word.
REQ-009 word_out  output  WIDTH  packed word.
REQ-010 word_len  output  $clog2(WIDTH+1)  number of valid bits in word_out.
REQ-011 word_valid  output  1  word_out/word_len valid.
REQ-012 word_ready  input  1  downstream accepts the word.

Function
REQ-013 A bit SHALL be accepted only on a clock edge with y_valid && y_ready; a word SHALL transfer only on an edge with word_valid && word_ready.
REQ-014 FSM states SHALL be FILL and STALL; y_ready SHALL be 1 in FILL and 0 in STALL, decoded from state only.
REQ-015 In FILL, each accepted bit SHALL be written into a shift register at the position set by LSB_FIRST and a bit counter cnt (0..WIDTH-1) SHALL increment.
REQ-016 When the accepted bit completes a word and the output register is free (!word_valid || word_ready), the word SHALL load into word_out with word_len=WIDTH, word_valid SHALL rise on the next cycle (1-cycle latency), cnt SHALL clear, and the state SHALL remain FILL.
REQ-017 When the accepted bit completes a word and the output register is occupied and not draining, the state SHALL go to STALL, holding the complete word.
REQ-018 In STALL, on word_ready the held word SHALL load into word_out and the state SHALL return to FILL with cnt=0.
REQ-019 flush in FILL with cnt>0 (after counting any simultaneously accepted bit) and output register free SHALL emit the partial word with unfilled positions zero and word_len=cnt; if the output register is busy, the flush SHALL be held pending until it is free.
REQ-020 flush with cnt=0, or in STALL, SHALL be ignored; a bit accepted in the flush cycle that completes a word SHALL follow REQ-016/017 with word_len=WIDTH.
REQ-021 word_valid SHALL stay asserted with word_out stable until accepted; with word_ready held high, sustained throughput SHALL be one bit per cycle with no gaps.

Reset
REQ-022 While rst_n=0: state=FILL, cnt=0, shift register=0, word_out=0, word_len=0, word_valid=0, flush-pending=0; y_ready SHALL read 1.
REQ-023 Reset asserted mid-word or mid-STALL SHALL discard all partial and held data; no word SHALL be emitted for it after release.

Configuration
REQ-024 With macro MUX2_PACK_PARITY_EN defined, output word_parity (1 bit, XOR of word_out) SHALL exist, registered with word_out, reset 0; without it, the port and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 Package mux2_pack_pkg SHALL hold the FSM state enum (FILL, STALL) and the default WIDTH constant.
REQ-026 Sub-module mux2_bit_counter (cnt with clear/increment/terminal-count flag) SHALL be instantiated once; all other logic is in the top module.

Verification (WIDTH=8, LSB_FIRST=1, word_ready=1 unless stated)
REQ-027 Alternating stream 1,0,1,0,1,0,1,0 on consecutive cycles -> one word 0x55, word_len=8, word_valid high exactly one cycle after the 8th bit; word_parity=0 when enabled.
REQ-028 Bits 1,0,0,1,1,0,1,0 -> 0x59; with LSB_FIRST=0 the same bits -> 0x9A.
REQ-029 Bits 1,1,0 then flush -> word 0x03, word_len=3; a subsequent flush with cnt=0 -> no word.
REQ-030 word_ready=0 and 16 bits offered -> first word held, y_ready drops to 0 after the 16th bit is accepted; word_ready=1 -> both words delivered in order, y_ready returns to 1.
REQ-031 rst_n pulsed low after 5 bits, then 8 bits 0xFF -> only word 0xFF emitted, word_len=8.

Source files
------------

// File: rtl/mux2_pack_pkg.sv
// Shared types and defaults for the 2:1-mux sample packer.
// Optional parity output is enabled with MUX2_PACK_PARITY_EN.
package mux2_pack_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;
endpackage

// File: rtl/mux2_bit_counter.sv
// Bit-position counter for the sample packer: clear wins over increment.
module mux2_bit_counter
    import mux2_pack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + CW'(1);
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/mux2_sample_packer.sv
// Packs the serial y stream of a 2:1 mux stage into WIDTH-bit words with flush.
// Define MUX2_PACK_PARITY_EN to add the registered word_parity output.
module mux2_sample_packer
    import mux2_pack_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b1,
    localparam int LW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             y_valid,
    output logic             y_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic [LW-1:0]    word_len,
    output logic             word_valid,
`ifdef MUX2_PACK_PARITY_EN
    output logic             word_parity,
`endif
    input  logic             word_ready
);
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_upd, w_load_word;
    logic [LW-1:0]    w_cnt, w_cnt_after, w_pos, w_load_len;
    logic             w_tc, w_acc, w_free, w_done, w_drain;
    logic             w_fl_req, w_fl_emit, w_load, r_fp;

    mux2_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_done || w_fl_emit),
        .i_inc (w_acc && !w_done),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    assign y_ready     = (r_state == FILL);
    assign w_acc       = y_valid && y_ready;
    assign w_free      = !word_valid || word_ready;
    assign w_done      = w_acc && w_tc;
    assign w_drain     = (r_state == STALL) && word_ready;
    assign w_cnt_after = w_cnt + LW'(w_acc);
    // A flush is judged on the count including this cycle's bit; a completing bit overrides it.
    assign w_fl_req    = (flush || r_fp) && (r_state == FILL) && !w_done && (w_cnt_after != '0);
    assign w_fl_emit   = w_fl_req && w_free;
    assign w_load      = (w_done && w_free) || w_fl_emit || w_drain;
    assign w_pos       = LSB_FIRST ? w_cnt : (LW'(WIDTH - 1) - w_cnt);
    assign w_sh_upd    = w_acc ? (r_sh | ({{(WIDTH-1){1'b0}}, y_in} << w_pos)) : r_sh;
    assign w_load_word = w_drain ? r_sh : w_sh_upd;
    assign w_load_len  = w_fl_emit ? w_cnt_after : LW'(WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_done && !w_free) w_state_nxt = STALL;
            STALL:   if (word_ready)        w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // Shift register stays at zero between words so partial flushes read zero-filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
            r_fp <= 1'b0;
        end else begin
            if (w_load)     r_sh <= '0;
            else if (w_acc) r_sh <= w_sh_upd;
            if (w_fl_emit || w_done) r_fp <= 1'b0;
            else if (w_fl_req)       r_fp <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out    <= '0;
            word_len    <= '0;
            word_valid  <= 1'b0;
`ifdef MUX2_PACK_PARITY_EN
            word_parity <= 1'b0;
`endif
        end else if (w_load) begin
            word_out    <= w_load_word;
            word_len    <= w_load_len;
            word_valid  <= 1'b1;
`ifdef MUX2_PACK_PARITY_EN
            word_parity <= ^w_load_word;
`endif
        end else if (word_ready) begin
            word_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux2_sample_packer.sv
// Directed bench for mux2_sample_packer: LSB-first and MSB-first instances share stimulus.
module tb_mux2_sample_packer;
    logic       clk = 1'b0;
    logic       rst_n, y_in, y_valid, flush, word_ready;
    logic       y_ready, word_valid, m_y_ready, m_word_valid;
    logic [7:0] word_out, m_word_out;
    logic [3:0] word_len, m_word_len;
`ifdef MUX2_PACK_PARITY_EN
    logic       word_parity, m_word_parity;
`endif

    typedef struct {
        logic [7:0] w;
        logic [3:0] len;
    } exp_t;

    exp_t q[$];
    exp_t qm[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mux2_sample_packer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
        .flush(flush), .word_out(word_out), .word_len(word_len), .word_valid(word_valid),
`ifdef MUX2_PACK_PARITY_EN
        .word_parity(word_parity),
`endif
        .word_ready(word_ready)
    );

    mux2_sample_packer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .y_ready(m_y_ready),
        .flush(flush), .word_out(m_word_out), .word_len(m_word_len), .word_valid(m_word_valid),
`ifdef MUX2_PACK_PARITY_EN
        .word_parity(m_word_parity),
`endif
        .word_ready(word_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic push(input logic [7:0] w, input logic [3:0] len);
        exp_t e;
        e.w = w; e.len = len;
        q.push_back(e);
        e.w = rev8(w);
        qm.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        y_in = b; y_valid = 1'b1;
        step();
    endtask

    task automatic put_bits(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) put_bit(seq[i]);
    endtask

    task automatic idle(input int n);
        y_valid = 1'b0; flush = 1'b0;
        repeat (n) step();
    endtask

    // Scoreboard: every transfer on either instance pops its own expected word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && word_valid && word_ready) begin
            chk("lsb_word_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lsb_word", word_out, e.w);
                chk("lsb_len", word_len, e.len);
            end
        end
        if (rst_n && m_word_valid && word_ready) begin
            chk("msb_word_expected", 32'(qm.size() > 0), 1);
            if (qm.size() > 0) begin
                e = qm.pop_front();
                chk("msb_word", m_word_out, e.w);
                chk("msb_len", m_word_len, e.len);
            end
        end
    end

    initial begin
        rst_n = 1'b0; y_in = 1'b0; y_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
        repeat (2) step();
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_out", word_out, 0);
        chk("rst_word_len", word_len, 0);
        chk("rst_y_ready", y_ready, 1);
        rst_n = 1'b1;
        idle(1);

        // Alternating stream, valid exactly one cycle after the 8th bit
        put_bits(8'h55, 7);
        chk("alt_not_yet_valid", word_valid, 0);
        push(8'h55, 8);
        put_bit(1'b0);
        chk("alt_valid", word_valid, 1);
        chk("alt_word", word_out, 8'h55);
        chk("alt_len", word_len, 8);
`ifdef MUX2_PACK_PARITY_EN
        chk("alt_parity", word_parity, 0);
`endif
        idle(2);

        push(8'h59, 8);
        put_bits(8'h59, 8);
        chk("msb_first_9a", m_word_out, 8'h9A);
        idle(2);

        // Back-to-back words with no gap
        push(8'hA3, 8);
        push(8'h3C, 8);
        put_bits(8'hA3, 8);
        put_bits(8'h3C, 8);
        chk("b2b_y_ready", y_ready, 1);
        idle(3);

        // Partial flush, then a flush with nothing buffered
        put_bits(8'h03, 3);
        push(8'h03, 3);
        y_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", word_valid, 1);
        chk("flush_len", word_len, 3);
        idle(1);
        flush = 1'b1;
        step();
        idle(3);
        chk("empty_flush_no_word", word_valid, 0);

        // Flush together with a word-completing bit, then with a partial bit
        put_bits(8'hE7, 7);
        push(8'hE7, 8);
        flush = 1'b1;
        put_bit(1'b1);
        flush = 1'b0;
        chk("flush_full_len", word_len, 8);
        put_bit(1'b1);
        push(8'h01, 2);
        flush = 1'b1;
        put_bit(1'b0);
        idle(3);

        // Backpressure: second word stalls, both delivered in order
        word_ready = 1'b0;
        push(8'hC5, 8);
        push(8'h1E, 8);
        put_bits(8'hC5, 8);
        put_bits(8'h1E, 7);
        chk("bp_ready_before_16", y_ready, 1);
        put_bit(1'b0);
        chk("bp_stall_y_ready", y_ready, 0);
        chk("bp_held_word", word_out, 8'hC5);
        put_bit(1'b1);
        put_bit(1'b1);
        chk("bp_still_stalled", y_ready, 0);
        y_valid = 1'b0;
        word_ready = 1'b1;
        step();
        chk("bp_ready_back", y_ready, 1);
        chk("bp_second_word", word_out, 8'h1E);
        idle(3);

        // Flush while output busy is held until the output frees
        word_ready = 1'b0;
        push(8'h0F, 8);
        put_bits(8'h0F, 8);
        put_bits(8'h03, 2);
        push(8'h03, 2);
        y_valid = 1'b0; flush = 1'b1;
        step();
        idle(2);
        chk("pend_word_stable", word_out, 8'h0F);
        word_ready = 1'b1;
        step();
        chk("pend_flush_word", word_out, 8'h03);
        chk("pend_flush_len", word_len, 2);
        idle(3);

        // Reset mid-word discards the partial bits
        put_bits(8'h05, 5);
        y_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", word_valid, 0);
        chk("midrst_y_ready", y_ready, 1);
        step();
        rst_n = 1'b1;
        idle(1);
        push(8'hFF, 8);
        put_bits(8'hFF, 8);
        idle(3);

        for (int i = 0; i < 50 && (q.size() + qm.size()) > 0; i++) step();
        chk("scoreboard_drained", 32'(q.size() + qm.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
